// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU main control: opcodes, state
// encodings, select codes and the control word handed to the datapath.
package cpu_ctrl_pkg;

   localparam int OPCODE_W = 6;
   localparam int STATE_W  = 4;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_RTYPE = 6'h00;
   localparam opcode_t OP_J     = 6'h02;
   localparam opcode_t OP_BEQ   = 6'h04;
   localparam opcode_t OP_ADDI  = 6'h08;
   localparam opcode_t OP_LW    = 6'h23;
   localparam opcode_t OP_SW    = 6'h2B;

   typedef enum logic [STATE_W-1:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDIEXEC = 4'd11,
      S_ADDIWB   = 4'd12
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_B       = 2'd0,
      SRCB_FOUR    = 2'd1,
      SRCB_IMM     = 2'd2,
      SRCB_IMM_SH2 = 2'd3
   } srcb_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pcsrc_e;

   // Everything the datapath needs from the control unit in one cycle.
   typedef struct packed {
      logic    pc_en;
      logic    ir_write;
      logic    ab_write;
      logic    aluout_write;
      logic    mem_read;
      logic    mem_write;
      logic    iord;
      logic    reg_write;
      logic    reg_dst;
      logic    mem_to_reg;
      logic    alu_src_a;
      srcb_e   alu_src_b;
      alu_op_e alu_op;
      pcsrc_e  pc_source;
      logic    illegal_op;
   } ctrl_t;

   // True for the opcodes this control unit knows how to sequence.
   function automatic logic op_is_legal(input opcode_t op);
      return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from the current control state to the datapath control
// word. Moore outputs, except pc_en (zero in BRANCH) and illegal_op (opcode
// in DECODE).
module ctrl_output_decode
   import cpu_ctrl_pkg::*;
(
   input  state_e  state_i,
   input  opcode_t opcode_i,
   input  logic    zero_i,
   output ctrl_t   ctrl_o
);

   logic pc_write;
   logic pc_write_cond;

   // Per-state control word; unlisted signals, RESET and unused codes give 0.
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      ctrl_o        = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            pc_write         = 1'b1;
         end
         S_DECODE: begin
            ctrl_o.ab_write     = 1'b1;
            ctrl_o.aluout_write = 1'b1;
            ctrl_o.alu_src_b    = SRCB_IMM_SH2;
            ctrl_o.alu_op       = ALU_ADD;
            ctrl_o.illegal_op   = ~op_is_legal(opcode_i);
         end
         S_MEMADR, S_ADDIEXEC: begin
            ctrl_o.alu_src_a    = 1'b1;
            ctrl_o.alu_src_b    = SRCB_IMM;
            ctrl_o.alu_op       = ALU_ADD;
            ctrl_o.aluout_write = 1'b1;
         end
         S_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
         end
         S_EXECUTE: begin
            ctrl_o.alu_src_a    = 1'b1;
            ctrl_o.alu_src_b    = SRCB_B;
            ctrl_o.alu_op       = ALU_FUNCT;
            ctrl_o.aluout_write = 1'b1;
         end
         S_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALU_SUB;
            ctrl_o.pc_source = PCSRC_ALUOUT;
            pc_write_cond    = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_source = PCSRC_JUMP;
            pc_write         = 1'b1;
         end
         S_ADDIWB: begin
            ctrl_o.reg_write = 1'b1;
         end
         default: ;
      endcase
      ctrl_o.pc_en = pc_write | (pc_write_cond & zero_i);
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle CPU: state register and next-state
// logic; the control word comes from ctrl_output_decode.
module multi_cycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int opcode_width = 6,
   parameter int state_width  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [opcode_width-1:0] opcode,
   input  logic                    zero,
   output logic                    pc_en,
   output logic                    ir_write,
   output logic                    ab_write,
   output logic                    aluout_write,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    iord,
   output logic                    reg_write,
   output logic                    reg_dst,
   output logic                    mem_to_reg,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              pc_source,
   output logic                    illegal_op,
   output logic [state_width-1:0]  state
);

   state_e  state_q, state_d;
   opcode_t op;
   ctrl_t   ctrl;

   assign op = opcode_t'(opcode);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignment; reset is sampled on the clock edge only.
      if (!reset) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   // Next-state sequencing; opcode is stable from DECODE onwards.
   always_comb begin
      state_d = S_RESET;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEXEC;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB:
                     state_d = S_FETCH;
         default:    state_d = S_RESET;
      endcase
   end

   ctrl_output_decode u_decode (
      .state_i  (state_q),
      .opcode_i (op),
      .zero_i   (zero),
      .ctrl_o   (ctrl)
   );

   assign pc_en        = ctrl.pc_en;
   assign ir_write     = ctrl.ir_write;
   assign ab_write     = ctrl.ab_write;
   assign aluout_write = ctrl.aluout_write;
   assign mem_read     = ctrl.mem_read;
   assign mem_write    = ctrl.mem_write;
   assign iord         = ctrl.iord;
   assign reg_write    = ctrl.reg_write;
   assign reg_dst      = ctrl.reg_dst;
   assign mem_to_reg   = ctrl.mem_to_reg;
   assign alu_src_a    = ctrl.alu_src_a;
   assign alu_src_b    = ctrl.alu_src_b;
   assign alu_op       = ctrl.alu_op;
   assign pc_source    = ctrl.pc_source;
   assign illegal_op   = ctrl.illegal_op;
   assign state        = state_width'(state_q);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed and random instruction streams
// compared cycle by cycle against a per-instruction expected trace.
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       pc_en, ir_write, ab_write, aluout_write, mem_read, mem_write;
   logic       iord, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   multi_cycle_control #(.opcode_width(6), .state_width(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .zero         (zero),
      .pc_en        (pc_en),
      .ir_write     (ir_write),
      .ab_write     (ab_write),
      .aluout_write (aluout_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .iord         (iord),
      .reg_write    (reg_write),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .pc_source    (pc_source),
      .illegal_op   (illegal_op),
      .state        (state)
   );

   always #5 clk = ~clk;

   // Expected outputs of one cycle, in the same order as obs below.
   typedef struct packed {
      logic [3:0] st;
      logic       pc_en, ir_write, ab_write, aluout_write, mem_read, mem_write;
      logic       iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] srcb, aluop, pcsrc;
      logic       illegal;
   } exp_t;

   logic [21:0] obs;
   assign obs = {state, pc_en, ir_write, ab_write, aluout_write, mem_read, mem_write,
                 iord, reg_write, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, alu_op, pc_source, illegal_op};

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic zq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
   endfunction

   // Build the cycle-by-cycle expected trace of one instruction, FETCH first.
   // zb is the zero flag presented in the BRANCH cycle; other cycles get noise.
   task automatic build(input logic [5:0] op, input logic zb);
      exp_t e;
      exp_q.delete();
      zq.delete();
      e = blank(4'd1); e.mem_read = 1; e.ir_write = 1; e.srcb = 2'd1; e.pc_en = 1;
      exp_q.push_back(e); zq.push_back(1'($urandom));
      e = blank(4'd2); e.ab_write = 1; e.aluout_write = 1; e.srcb = 2'd3; e.illegal = !legal(op);
      exp_q.push_back(e); zq.push_back(1'($urandom));
      case (op)
         6'h23, 6'h2B: begin
            e = blank(4'd3); e.alu_src_a = 1; e.srcb = 2'd2; e.aluout_write = 1;
            exp_q.push_back(e); zq.push_back(1'($urandom));
            if (op == 6'h23) begin
               e = blank(4'd4); e.mem_read = 1; e.iord = 1;
               exp_q.push_back(e); zq.push_back(1'($urandom));
               e = blank(4'd5); e.reg_write = 1; e.mem_to_reg = 1;
               exp_q.push_back(e); zq.push_back(1'($urandom));
            end else begin
               e = blank(4'd6); e.mem_write = 1; e.iord = 1;
               exp_q.push_back(e); zq.push_back(1'($urandom));
            end
         end
         6'h00: begin
            e = blank(4'd7); e.alu_src_a = 1; e.aluop = 2'd2; e.aluout_write = 1;
            exp_q.push_back(e); zq.push_back(1'($urandom));
            e = blank(4'd8); e.reg_write = 1; e.reg_dst = 1;
            exp_q.push_back(e); zq.push_back(1'($urandom));
         end
         6'h04: begin
            e = blank(4'd9); e.alu_src_a = 1; e.aluop = 2'd1; e.pcsrc = 2'd1; e.pc_en = zb;
            exp_q.push_back(e); zq.push_back(zb);
         end
         6'h02: begin
            e = blank(4'd10); e.pc_en = 1; e.pcsrc = 2'd2;
            exp_q.push_back(e); zq.push_back(1'($urandom));
         end
         6'h08: begin
            e = blank(4'd11); e.alu_src_a = 1; e.srcb = 2'd2; e.aluout_write = 1;
            exp_q.push_back(e); zq.push_back(1'($urandom));
            e = blank(4'd12); e.reg_write = 1;
            exp_q.push_back(e); zq.push_back(1'($urandom));
         end
         default: ;
      endcase
   endtask

   // Play one instruction starting in FETCH. n < 0 runs it to completion;
   // otherwise stop after checking cycle n-1, without advancing the clock.
   task automatic run_instr(input logic [5:0] op, input logic zb, input int n);
      int len;
      build(op, zb);
      len = (n < 0) ? exp_q.size() : n;
      for (int i = 0; i < len; i++) begin
         opcode = (i == 0) ? 6'($urandom) : op;
         zero   = zq[i];
         @(negedge clk);
         check($sformatf("op%02h cyc%0d", op, i), 32'(obs), 32'(exp_q[i]));
         check($sformatf("op%02h cyc%0d rd_wr_excl", op, i), 32'(mem_read & mem_write), 32'd0);
         if (i == len - 1 && n >= 0) break;
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [5:0] LEGAL_OPS [6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};

   initial begin
      logic [5:0] op;
      reset  = 1'b0;
      opcode = 6'h3F;
      zero   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_idle", 32'(obs), 32'(blank(4'd0)));
      reset = 1'b1;
      @(posedge clk);
      #1;

      // lw interrupted in MEMRD by a three-edge reset
      run_instr(6'h23, 1'b0, 4);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("reset_mid_lw%0d", k), 32'(obs), 32'(blank(4'd0)));
      end
      reset = 1'b1;
      @(posedge clk);
      #1;

      // directed instructions
      run_instr(6'h23, 1'b0, -1);
      run_instr(6'h2B, 1'b0, -1);
      run_instr(6'h04, 1'b1, -1);
      run_instr(6'h04, 1'b0, -1);
      run_instr(6'h00, 1'b0, -1);
      run_instr(6'h08, 1'b0, -1);
      run_instr(6'h3F, 1'b0, -1);
      run_instr(6'h02, 1'b0, -1);

      // random instruction stream, mostly legal opcodes
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(3) != 0) op = LEGAL_OPS[$urandom_range(5)];
         else                        op = 6'($urandom);
         run_instr(op, 1'($urandom), -1);
      end

      // the last instruction must have returned to FETCH
      @(negedge clk);
      check("final_fetch", 32'(state), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
